// File: rtl/mac_pipe.sv
// mac_pipe: two-stage pipelined multiply-add / multiply-accumulate unit.
// Stage 1 registers the product; stage 2 applies the op against the accumulator and presents the result.
module mac_pipe #(
   parameter int DATA_W = 8,
   parameter int OUT_W  = 20
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [1:0]        op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [DATA_W-1:0] c_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [OUT_W-1:0]  d_o,
   output logic              ovf_o
);

   localparam int PROD_W = 2 * DATA_W;
   localparam int SUM_W  = OUT_W + 1;
   localparam logic [OUT_W-1:0] ACC_MAX = {OUT_W{1'b1}};

   localparam logic [1:0] OP_MAC_LOAD = 2'b01;
   localparam logic [1:0] OP_MAC_ACC  = 2'b10;

   if (OUT_W < 2 * DATA_W) begin : g_bad_width
      $error("mac_pipe: OUT_W must be >= 2*DATA_W");
   end

   logic              s1_valid_q, s1_valid_d;
   logic [PROD_W-1:0] s1_prod_q, s1_prod_d;
   logic [DATA_W-1:0] s1_c_q, s1_c_d;
   logic [1:0]        s1_op_q, s1_op_d;
   logic              out_valid_q, out_valid_d;
   logic [OUT_W-1:0]  d_q, d_d;
   logic [OUT_W-1:0]  acc_q, acc_d;
   logic              ovf_q, ovf_d;

   logic              s2_adv;
   logic              in_ready;
   logic              in_fire;
   logic [OUT_W-1:0]  prod_plus_c;
   logic [SUM_W-1:0]  acc_sum;

   always_comb begin
      s2_adv      = !out_valid_q || out_ready_i;
      in_ready    = !s1_valid_q || s2_adv;
      in_fire     = in_valid_i && in_ready;
      prod_plus_c = OUT_W'(s1_prod_q) + OUT_W'(s1_c_q);
      acc_sum     = SUM_W'(acc_q) + SUM_W'(s1_prod_q);

      s1_valid_d  = s1_valid_q;
      s1_prod_d   = s1_prod_q;
      s1_c_d      = s1_c_q;
      s1_op_d     = s1_op_q;
      out_valid_d = out_valid_q;
      d_d         = d_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;

      // Stage 1 may fill while stage 2 stalls if it was empty.
      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_prod_d  = a_i * b_i;
         s1_c_d     = c_i;
         s1_op_d    = op_i;
      end else if (s2_adv) begin
         s1_valid_d = 1'b0;
      end

      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            case (s1_op_q)
               OP_MAC_LOAD: begin
                  acc_d = prod_plus_c;
                  ovf_d = 1'b0;
                  d_d   = prod_plus_c;
               end
               OP_MAC_ACC: begin
                  if (acc_sum[OUT_W]) begin
                     acc_d = ACC_MAX;
                     ovf_d = 1'b1;
                  end else begin
                     acc_d = acc_sum[OUT_W-1:0];
                  end
                  d_d = acc_d;
               end
               default: begin
                  d_d = prod_plus_c;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_q  <= 1'b0;
         s1_prod_q   <= '0;
         s1_c_q      <= '0;
         s1_op_q     <= '0;
         out_valid_q <= 1'b0;
         d_q         <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_prod_q   <= s1_prod_d;
         s1_c_q      <= s1_c_d;
         s1_op_q     <= s1_op_d;
         out_valid_q <= out_valid_d;
         d_q         <= d_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
      end
   end

   assign in_ready_o  = in_ready;
   assign out_valid_o = out_valid_q;
   assign d_o         = d_q;
   assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Bench for mac_pipe: directed scenarios plus randomized traffic, checked by a
// queue-based scoreboard fed from an arithmetic reference model.
module tb_mac_pipe;

   localparam int DATA_W = 8;
   localparam int OUT_W  = 20;
   localparam longint MAXV = (64'd1 << OUT_W) - 1;

   logic              clk_i;
   logic              rst_ni;
   logic              in_valid_i;
   logic              in_ready_o;
   logic [1:0]        op_i;
   logic [DATA_W-1:0] a_i, b_i, c_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [OUT_W-1:0]  d_o;
   logic              ovf_o;

   logic dir_rdy;
   logic rnd_rdy;
   logic rand_bp;
   assign out_ready_i = rand_bp ? rnd_rdy : dir_rdy;

   int checks;
   int failures;

   logic [OUT_W-1:0] exp_q[$];
   logic             exp_ovf_q[$];
   longint           mdl_acc;
   logic             mdl_ovf;

   mac_pipe #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .op_i        (op_i),
      .a_i         (a_i),
      .b_i         (b_i),
      .c_i         (c_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .d_o         (d_o),
      .ovf_o       (ovf_o)
   );

   // clock / reset
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      rnd_rdy = 1'b1;
      forever begin
         @(posedge clk_i);
         #2;
         rnd_rdy = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // reference model: acceptance-ordered arithmetic on plain integers
   task automatic model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c);
      longint prod;
      longint res;
      prod = longint'(a) * longint'(b);
      if (op == 2'b01) begin
         mdl_acc = prod + longint'(c);
         mdl_ovf = 1'b0;
         res     = mdl_acc;
      end else if (op == 2'b10) begin
         mdl_acc = mdl_acc + prod;
         if (mdl_acc > MAXV) begin
            mdl_acc = MAXV;
            mdl_ovf = 1'b1;
         end
         res = mdl_acc;
      end else begin
         res = prod + longint'(c);
      end
      exp_q.push_back(OUT_W'(res));
      exp_ovf_q.push_back(mdl_ovf);
   endtask

   // driver: hold the beat until accepted, bounded
   task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c);
      bit done;
      bit rdy;
      done = 0;
      in_valid_i = 1'b1;
      op_i = op;
      a_i  = a;
      b_i  = b;
      c_i  = c;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk_i);
         rdy = in_ready_o;
         @(posedge clk_i);
         if (rdy) begin
            done = 1;
            model(op, a, b, c);
         end
      end
      #1;
      in_valid_i = 1'b0;
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=not_accepted expected=accepted");
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk_i);
         n++;
      end
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
      @(posedge clk_i);
      #1;
   endtask

   // monitor / scoreboard
   always @(negedge clk_i) begin
      if (rst_ni && out_valid_o && out_ready_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out actual=%0d expected=no_beat", d_o);
         end else begin
            chk("sb_d", 64'(d_o), 64'(exp_q.pop_front()));
            chk("sb_ovf", 64'(ovf_o), 64'(exp_ovf_q.pop_front()));
         end
      end
   end

   initial begin
      checks = 0;
      failures = 0;
      mdl_acc = 0;
      mdl_ovf = 1'b0;
      rand_bp = 1'b0;
      dir_rdy = 1'b1;
      in_valid_i = 1'b0;
      op_i = '0;
      a_i = '0;
      b_i = '0;
      c_i = '0;

      // reset / idle
      rst_ni = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("rst_out_valid", 64'(out_valid_o), 64'd0);
      chk("rst_d", 64'(d_o), 64'd0);
      chk("rst_ovf", 64'(ovf_o), 64'd0);
      chk("rst_in_ready", 64'(in_ready_o), 64'd1);
      @(posedge clk_i);
      #1;

      // MULADD corner with latency check
      send(2'b00, 8'd255, 8'd255, 8'd255);
      chk("lat_not_early", 64'(out_valid_o), 64'd0);
      @(posedge clk_i);
      #1;
      chk("lat_valid", 64'(out_valid_o), 64'd1);
      chk("lat_d", 64'(d_o), 64'd65280);
      drain();

      // accumulate chain
      send(2'b01, 8'd3, 8'd4, 8'd5);
      send(2'b10, 8'd2, 8'd10, 8'd99);
      send(2'b00, 8'd1, 8'd1, 8'd1);
      send(2'b10, 8'd1, 8'd3, 8'd77);
      drain();
      chk("chain_last_d", 64'(d_o), 64'd40);

      // saturation
      send(2'b01, 8'd255, 8'd255, 8'd0);
      for (int i = 0; i < 18; i++) send(2'b10, 8'd255, 8'd255, 8'($urandom_range(0, 255)));
      drain();
      chk("sat_d", 64'(d_o), 64'd1048575);
      chk("sat_ovf", 64'(ovf_o), 64'd1);
      send(2'b01, 8'd1, 8'd1, 8'd0);
      drain();
      chk("reload_d", 64'(d_o), 64'd1);
      chk("reload_ovf", 64'(ovf_o), 64'd0);

      // backpressure
      dir_rdy = 1'b0;
      send(2'b00, 8'd1, 8'd2, 8'd0);
      send(2'b00, 8'd2, 8'd2, 8'd0);
      in_valid_i = 1'b1;
      op_i = 2'b00;
      a_i = 8'd3;
      b_i = 8'd2;
      c_i = 8'd0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         chk("bp_in_ready", 64'(in_ready_o), 64'd0);
         chk("bp_valid", 64'(out_valid_o), 64'd1);
         chk("bp_d_hold", 64'(d_o), 64'd2);
      end
      @(posedge clk_i);
      #1;
      dir_rdy = 1'b1;
      send(2'b00, 8'd3, 8'd2, 8'd0);
      drain();

      // reset mid-flight
      send(2'b01, 8'd10, 8'd10, 8'd0);
      rst_ni = 1'b0;
      exp_q.delete();
      exp_ovf_q.delete();
      mdl_acc = 0;
      mdl_ovf = 1'b0;
      @(negedge clk_i);
      chk("midrst_no_valid", 64'(out_valid_o), 64'd0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("midrst_no_valid2", 64'(out_valid_o), 64'd0);
      @(posedge clk_i);
      #1;
      send(2'b10, 8'd1, 8'd1, 8'd42);
      drain();
      chk("midrst_acc_d", 64'(d_o), 64'd1);

      // randomized traffic with random backpressure
      rand_bp = 1'b1;
      for (int i = 0; i < 300; i++) begin
         logic [1:0] op;
         logic [7:0] a, b;
         op = 2'($urandom_range(0, 3));
         a = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(200, 255)) : 8'($urandom);
         b = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(200, 255)) : 8'($urandom);
         send(op, a, b, 8'($urandom));
      end
      rand_bp = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mac_pipe.md
Name: mac_pipe

Overview:
- Parametrised, 2-stage pipelined multiply-add / multiply-accumulate unit.
- Next generation of the 8-bit combinational `a*b+c` datapath.
- Adds configurable width, valid/ready flow control with backpressure, a persistent accumulator with per-transaction op select, and saturating accumulation with a sticky overflow flag.
- Sits between an operand producer and a result consumer in the arithmetic datapath.

Parameters:
DATA_W, 8, width of unsigned operands a_i, b_i, c_i
OUT_W, 20, width of result/accumulator; must be >= 2*DATA_W (elaboration error otherwise)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  asynchronous active-low reset
in_valid_i  in  1  operand beat valid
in_ready_o  out  1  unit can accept operand beat
op_i  in  2  00 MULADD, 01 MAC_LOAD, 10 MAC_ACC, 11 reserved (treated as MULADD)
a_i  in  DATA_W  multiplicand, unsigned
b_i  in  DATA_W  multiplier, unsigned
c_i  in  DATA_W  addend, unsigned
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts result
d_o  out  OUT_W  result
ovf_o  out  1  sticky accumulator saturation flag

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk_i, rst_ni).
- Reset values:
  - out_valid_o=0, d_o=0, ovf_o=0.
  - Accumulator=0.
  - Stage-1 valid=0.
  - in_ready_o=1 once reset is deasserted.
- Handshakes:
  - Input transfer when in_valid_i & in_ready_o.
  - Output transfer when out_valid_o & out_ready_i.
  - Inputs are sampled only on an input transfer.
- Stage 1 registers:
  - prod = a_i*b_i, full 2*DATA_W bits.
  - c_i, op_i, valid.
- Stage 2 registers: d_o, out_valid_o, accumulator, ovf_o.
- Advance rules:
  - s2_adv = !out_valid_o | out_ready_i.
  - s1_adv = s2_adv.
  - in_ready_o = !s1_valid | s2_adv. This is a combinational path from out_ready_i; it is intended.
- Latency and throughput:
  - Beat accepted at edge k appears on d_o with out_valid_o=1 after edge k+1 (2-cycle latency).
  - Throughput is 1 beat/cycle when out_ready_i=1.
- Stall:
  - While out_valid_o=1 and out_ready_i=0, d_o, out_valid_o, accumulator, ovf_o and stage 1 hold.
  - At most 2 beats are in flight.
- Stage-2 load (on s2_adv with s1_valid=1), per op:
  - MULADD:
    - d_o = prod + c, zero-extended to OUT_W.
    - Never overflows, since OUT_W >= 2*DATA_W.
    - Accumulator and ovf_o unchanged.
  - MAC_LOAD:
    - acc = prod + c.
    - d_o = new acc.
    - ovf_o cleared to 0.
  - MAC_ACC:
    - sum = acc + prod, computed in OUT_W+1 bits.
    - If sum > 2^OUT_W-1: acc = 2^OUT_W-1 and ovf_o set to 1 (sticky).
    - Otherwise acc = sum.
    - d_o = new acc.
    - Once saturated, further MAC_ACC keeps acc at max.
- Stage-2 bubble (s2_adv with s1_valid=0): out_valid_o=0. d_o holds its last value; consumers must not sample it.
- Back-to-back MAC_ACC beats each see the accumulator updated by the previous beat; there are no hazard bubbles.
- An interleaved MULADD does not disturb the accumulator.
- MAC_ACC before any MAC_LOAD accumulates onto the reset value 0.
- Reset mid-operation:
  - All in-flight beats are discarded.
  - Accumulator and ovf_o return to 0.
  - No out_valid_o pulse occurs for discarded beats.

Test Plan:
- Reset / idle: hold rst_ni=0, then release -> out_valid_o=0, d_o=0, ovf_o=0, in_ready_o=1.
- MULADD corner:
  - Stimulus: a=255, b=255, c=255, op=00, out_ready_i=1.
  - Response: d_o=65280 with out_valid_o=1 exactly 2 cycles after acceptance.
- Accumulate chain (all back-to-back, out_ready_i=1):
  - Beats: MAC_LOAD(3,4,5), MAC_ACC(2,10,x), MULADD(1,1,1), MAC_ACC(1,3,x).
  - Response: d_o sequence 17, 37, 2, 40 on consecutive cycles.
- Saturation, OUT_W=20:
  - Stimulus: MAC_LOAD(255,255,0), then 16 x MAC_ACC(255,255,x).
  - Response: d_o 65025 ... 1040400 with ovf_o=0, then the 17th beat gives 1048575 and ovf_o=1.
  - Follow-up: further MAC_ACC stays 1048575; a subsequent MAC_LOAD(1,1,0) gives d_o=1, ovf_o=0.
- Backpressure:
  - Stimulus: out_ready_i=0, offer MULADD(1,2,0), (2,2,0), (3,2,0) continuously.
  - Response: first two accepted, in_ready_o=0 afterwards, d_o=2 held stable.
  - Release out_ready_i: d_o 2, 4, 6 delivered in order, no loss or duplication.
- Reset mid-flight:
  - Stimulus: MAC_LOAD(10,10,0) accepted, then rst_ni pulsed low one cycle later.
  - Response: no out_valid_o for that beat; a following MAC_ACC(1,1,x) yields d_o=1.
